// File: rtl/mul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_pkg : operand/product widths and requester state for mul_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
package mul_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } req_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first eligible at/after ptr. Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_next
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan upward from ptr with wrap; the pointer only moves when someone wins.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PW'((int'(idx) + 1) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_arbiter : shares one pipelined 16x16 signed multiplier among NREQ
//               requesters with tagged in-flight ops and result buffers. Rev 1.0
// ----------------------------------------------------------------------------
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_W-1:0]     req_a,
  input  logic [NREQ*OP_W-1:0]     req_b,
  output logic                     mul_valid,
  output logic [OP_W-1:0]          mul_a,
  output logic [OP_W-1:0]          mul_b,
  input  logic [PROD_W-1:0]        mul_p,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [NREQ*PROD_W-1:0]   rsp_p,
  output logic                     busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  req_state_e        state      [NREQ];
  req_state_e        state_next [NREQ];
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   grant;
  logic              any_grant;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     rr_ptr_next;
  logic [IW-1:0]     win_idx;
  logic [OP_W-1:0]   sel_a;
  logic [OP_W-1:0]   sel_b;
  logic [LAT:0]      tag_vld;
  logic [IW-1:0]     tag_idx    [LAT+1];
  logic              cap_vld;
  logic [IW-1:0]     cap_idx;
  logic [PROD_W-1:0] rsp_buf    [NREQ];

  // Gating with rst keeps req_ready low for the whole reset cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (state[i] == ST_IDLE) && !rst;
    end
  end

  rr_arbiter #(
    .N  (NREQ),
    .PW (IW)
  ) u_rr (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .ptr_next (rr_ptr_next)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    win_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_idx = IW'(i);
        sel_a   = req_a[i*OP_W +: OP_W];
        sel_b   = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      rr_ptr    <= '0;
    end else begin
      mul_valid <= any_grant;
      rr_ptr    <= rr_ptr_next;
      if (any_grant) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
    end
  end

  // Tag pipe: stage LAT lines up with the cycle the matching product is on mul_p.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_idx[s] <= '0;
      end
    end else begin
      tag_vld    <= {tag_vld[LAT-1:0], any_grant};
      tag_idx[0] <= win_idx;
      for (int s = 1; s <= LAT; s++) begin
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  assign cap_vld = tag_vld[LAT];
  assign cap_idx = tag_idx[LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        state[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        state[i] <= state_next[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_next[i] = state[i];
      case (state[i])
        ST_IDLE: if (grant[i]) state_next[i] = ST_BUSY;
        ST_BUSY: if (cap_vld && (cap_idx == IW'(i))) state_next[i] = ST_DONE;
        ST_DONE: if (rsp_ready[i]) state_next[i] = ST_IDLE;
        default: state_next[i] = ST_IDLE;
      endcase
    end
  end

  // Only the single BUSY owner of a tag is ever written, so a held DONE result stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        rsp_buf[i] <= '0;
      end
    end else if (cap_vld) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cap_idx == IW'(i)) begin
          rsp_buf[i] <= mul_p;
        end
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    assign rsp_valid[i]                 = (state[i] == ST_DONE);
    assign rsp_p[i*PROD_W +: PROD_W]    = rsp_buf[i];
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      busy = busy | (state[i] != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// tb_mul_arbiter : random + directed stimulus against a completion-queue model.
module tb_mul_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int S_I  = 0;
  localparam int S_B  = 1;
  localparam int S_D  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_a = '0;
  logic [NREQ*16-1:0] req_b = '0;
  logic               mul_valid;
  logic [15:0]        mul_a;
  logic [15:0]        mul_b;
  logic [31:0]        mul_p;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready = '0;
  logic [NREQ*32-1:0] rsp_p;
  logic               busy;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Shared multiplier: LAT-cycle pipeline; garbage on idle slots so stray captures show.
  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? smul(mul_a, mul_b) : 32'($urandom);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_p = mpipe[LAT-1];

  typedef struct {
    int          idx;
    int          cyc;
    logic [31:0] p;
  } fl_t;

  fl_t         fl [$];
  int          m_st  [NREQ];
  int          nst   [NREQ];
  logic [31:0] m_res [NREQ];
  int          m_ptr;
  logic        m_mv;
  logic [15:0] m_a;
  logic [15:0] m_b;
  int          g;
  int          ii;
  logic [NREQ-1:0] exp_ready;
  logic        exp_busy;

  // Reference model: compare the current cycle at negedge, then advance over the coming edge.
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      m_st[i]  = S_I;
      m_res[i] = '0;
    end
    m_ptr = 0;
    m_mv  = 1'b0;
    m_a   = '0;
    m_b   = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g = -1;
      if (!rst) begin
        for (int k = 0; k < NREQ; k++) begin
          ii = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[ii] && m_st[ii] == S_I) g = ii;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_busy = 1'b0;
      for (int i = 0; i < NREQ; i++) if (m_st[i] != S_I) exp_busy = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("mul_valid", 64'(mul_valid), 64'(m_mv));
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));
      chk("busy", 64'(busy), 64'(exp_busy));
      for (int i = 0; i < NREQ; i++) begin
        chk($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(m_st[i] == S_D));
        chk($sformatf("rsp_p[%0d]", i), 64'(rsp_p[i*32 +: 32]), 64'(m_res[i]));
      end
      if (rst) begin
        for (int i = 0; i < NREQ; i++) begin
          m_st[i]  = S_I;
          m_res[i] = '0;
        end
        m_ptr = 0;
        m_mv  = 1'b0;
        m_a   = '0;
        m_b   = '0;
        fl.delete();
      end else begin
        for (int i = 0; i < NREQ; i++) nst[i] = m_st[i];
        for (int q = fl.size() - 1; q >= 0; q--) begin
          if (fl[q].cyc == cyc) begin
            nst[fl[q].idx]   = S_D;
            m_res[fl[q].idx] = fl[q].p;
            fl.delete(q);
          end
        end
        for (int i = 0; i < NREQ; i++) if (m_st[i] == S_D && rsp_ready[i]) nst[i] = S_I;
        m_mv = (g >= 0);
        if (g >= 0) begin
          nst[g] = S_B;
          m_a    = req_a[g*16 +: 16];
          m_b    = req_b[g*16 +: 16];
          fl.push_back('{g, cyc + 1 + LAT, smul(m_a, m_b)});
          m_ptr  = (g + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) m_st[i] = nst[i];
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
  endtask

  // Single isolated operation with literal expectations on issue, latency and product.
  task automatic run_single(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp_p, input string tag);
    int n;
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    step();
    req_valid[i] = 1'b0;
    chk({tag, " mul_valid"}, 64'(mul_valid), 64'd1);
    chk({tag, " mul_a"}, 64'(mul_a), 64'(a));
    chk({tag, " mul_b"}, 64'(mul_b), 64'(b));
    n = 1;
    while (!rsp_valid[i] && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(LAT + 2));
    chk({tag, " rsp_p"}, 64'(rsp_p[i*32 +: 32]), 64'(exp_p));
    rsp_ready[i] = 1'b1;
    step();
    rsp_ready[i] = 1'b0;
    step();
  endtask

  logic [NREQ-1:0] onehot;
  logic [15:0]     edge_ops [5];

  initial begin
    edge_ops[0] = 16'h8000;
    edge_ops[1] = 16'h7FFF;
    edge_ops[2] = 16'hFFFF;
    edge_ops[3] = 16'h0000;
    edge_ops[4] = 16'h0001;

    step(); step(); step();
    chk("reset mul_valid", 64'(mul_valid), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_p", 64'(rsp_p[63:0]), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    run_single(0, 16'h0003, 16'hFFFE, 32'hFFFFFFFA, "t1");

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    rand_ops();
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < NREQ; k++) begin
      #1;
      onehot    = '0;
      onehot[k] = 1'b1;
      chk("t2 grant order", 64'(req_ready), 64'(onehot));
      step();
    end
    req_valid = '0;
    repeat (8) step();

    req_valid = 4'b1010;
    repeat (24) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (8) step();

    rsp_ready = 4'b1011;
    req_valid = '1;
    repeat (25) begin
      rand_ops();
      step();
    end
    #1;
    chk("t4 rsp_valid[2] held", 64'(rsp_valid[2]), 64'd1);
    chk("t4 req_ready[2]", 64'(req_ready[2]), 64'd0);
    step();
    rsp_ready = '1;
    req_valid = '0;
    repeat (8) step();
    rsp_ready = '0;

    set_op(0, 16'h1234, 16'h0101);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    chk("t5 mul_valid", 64'(mul_valid), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5 mul_valid reset", 64'(mul_valid), 64'd0);
    chk("t5 mul_a reset", 64'(mul_a), 64'd0);
    chk("t5 rsp_p reset", 64'(rsp_p[63:0]), 64'd0);
    chk("t5 busy reset", 64'(busy), 64'd0);
    repeat (6) begin
      step();
      chk("t5 no rsp", 64'(rsp_valid), 64'd0);
    end

    run_single(0, 16'h8000, 16'h8000, 32'h40000000, "t6a");
    run_single(3, 16'h7FFF, 16'h8000, 32'hC0008000, "t6b");

    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_op(i, edge_ops[$urandom_range(0, 4)], edge_ops[$urandom_range(0, 4)]);
        else
          set_op(i, 16'($urandom), 16'($urandom));
      end
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom) | NREQ'($urandom);
      rst       = ($urandom_range(0, 63) == 0);
      step();
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
